// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg: shared fuzzy set indices, id width and fuzzifier FSM encoding
package fuzzy_pkg;
    localparam logic [1:0] ERR_NB = 2'd0;
    localparam logic [1:0] ERR_NS = 2'd1;
    localparam logic [1:0] ERR_PS = 2'd2;
    localparam logic [1:0] ERR_PB = 2'd3;
    localparam logic [1:0] DE_N = 2'd0;
    localparam logic [1:0] DE_Z = 2'd1;
    localparam logic [1:0] DE_P = 2'd2;
    localparam int NUM_ERR_SETS = 4;
    localparam int NUM_DE_SETS = 3;
    localparam int SET_ID_W = 8;
    typedef enum logic [1:0] {IDLE, DIFF, CLASS, OUT} state_t;
endpackage

// File: rtl/fuzzy_classify.sv
// fuzzy_classify: maps (e, de) onto combined set id e_idx*3 + de_idx
// Ports: e, de signed error and change-in-error; e_big, de_band thresholds; id combined set id.
module fuzzy_classify import fuzzy_pkg::*; (
    input  logic signed [15:0]   e,
    input  logic signed [15:0]   de,
    input  logic signed [15:0]   e_big,
    input  logic signed [15:0]   de_band,
    output logic [SET_ID_W-1:0]  id
);
    logic [1:0] e_idx;
    logic [1:0] de_idx;
    always_comb begin
        e_idx = e <= -e_big ? ERR_NB : e < 0 ? ERR_NS : e < e_big ? ERR_PS : ERR_PB;
        de_idx = de < -de_band ? DE_N : de > de_band ? DE_P : DE_Z;
        id = SET_ID_W'(e_idx) * SET_ID_W'(NUM_DE_SETS) + SET_ID_W'(de_idx);
    end
endmodule

// File: rtl/fuzzifier.sv
// fuzzifier: turns frequency-error samples into combined fuzzy set ids
// Ports: clk, rst (sync, active-high); sample_valid/sample_ready/freq_error sample handshake;
// sync_clear restarts history; fuzzy_set_id/set_valid result with one-cycle strobe.
module fuzzifier import fuzzy_pkg::*; #(
    parameter logic signed [15:0] E_BIG = 16'sd1000,
    parameter logic signed [15:0] DE_BAND = 16'sd50
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    input  logic signed [15:0]   freq_error,
    input  logic                 sync_clear,
    output logic                 sample_ready,
    output logic [SET_ID_W-1:0]  fuzzy_set_id,
    output logic                 set_valid
);
    state_t state, next_state;
    logic signed [15:0] e, e_prev, de, de_sat;
    logic signed [16:0] diff;
    logic prev_valid, accept;
    logic [SET_ID_W-1:0] id;
    always_comb begin
        sample_ready = state == IDLE;
        accept = sample_valid && sample_ready;
        next_state = state == IDLE ? (accept ? DIFF : IDLE) : state == DIFF ? CLASS : state == CLASS ? OUT : IDLE;
        diff = {e[15], e} - {e_prev[15], e_prev};
        // top two bits disagree only when the 17-bit difference leaves the 16-bit range
        de_sat = diff[16] ^ diff[15] ? (diff[16] ? 16'sh8000 : 16'sh7fff) : diff[15:0];
    end
    fuzzy_classify u_classify (
        .e       (e),
        .de      (de),
        .e_big   (E_BIG),
        .de_band (DE_BAND),
        .id      (id)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            e <= '0;
            e_prev <= '0;
            de <= '0;
            prev_valid <= 1'b0;
            fuzzy_set_id <= '0;
            set_valid <= 1'b0;
        end else begin
            state <= next_state;
            set_valid <= state == CLASS;
            if (accept) e <= freq_error;
            if (state == DIFF) begin
                de <= prev_valid && !sync_clear ? de_sat : 16'sd0;
                e_prev <= e;
            end
            prev_valid <= sync_clear ? 1'b0 : state == DIFF ? 1'b1 : prev_valid;
            if (state == CLASS) fuzzy_set_id <= id;
        end
    end
endmodule
